input_port_controller: RTL and testbench

- Per-input-port front end of a mesh router, placed directly upstream of the switch control unit.
- Buffers incoming flits in a FIFO and computes the XY route from the head flit.
- Holds a route-reserve request toward the switch control until the path is granted, then streams the packet to the crossbar.
- After the tail flit leaves, pulses route-relieve to free the output.
- One instance per router input; its request/relieve ports map 1:1 onto one input slot of the switch control.

---
 rtl/input_port_controller.sv | 121 ++++++++++++
 tb/tb_input_port_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/input_port_controller.sv
// Mesh router input port: buffers flits, computes the XY route from the head flit,
// and holds the path reservation with switch control until the tail flit has left.
module input_port_controller #(
    parameter int N             = 4,
    parameter int X_POS         = 0,
    parameter int Y_POS         = 0,
    parameter int DATA_WIDTH    = 16,
    parameter int REQUEST_WIDTH = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     routeReserveRequestValid,
    output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
    output logic                     routeRelieve,
    input  logic                     routeReserveStatus,
    input  logic                     PortReserved,
    output logic                     flit_error
);
    localparam int AW = $clog2(N);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] XP = AW'(X_POS);
    localparam logic [AW-1:0] YP = AW'(Y_POS);

    localparam logic [REQUEST_WIDTH-1:0] P_LOCAL = REQUEST_WIDTH'(0);
    localparam logic [REQUEST_WIDTH-1:0] P_EAST  = REQUEST_WIDTH'(1);
    localparam logic [REQUEST_WIDTH-1:0] P_WEST  = REQUEST_WIDTH'(2);
    localparam logic [REQUEST_WIDTH-1:0] P_NORTH = REQUEST_WIDTH'(3);
    localparam logic [REQUEST_WIDTH-1:0] P_SOUTH = REQUEST_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, REQUEST, FORWARD} state_t;

    logic [DATA_WIDTH-1:0] fifoMem [FIFO_DEPTH];
    logic [PW-1:0]         wrPtr, rdPtr;
    logic [CW-1:0]         count;
    logic                  empty, full, push, pop, errDrop;
    logic [1:0]            headType;
    logic [AW-1:0]         destX, destY;
    logic [REQUEST_WIDTH-1:0] routePort;
    state_t                state;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign in_ready = ~full & ~rst;
    assign push     = in_valid & in_ready;

    assign out_data = fifoMem[rdPtr];
    assign headType = fifoMem[rdPtr][DATA_WIDTH-1 -: 2];
    assign destX    = fifoMem[rdPtr][0 +: AW];
    assign destY    = fifoMem[rdPtr][AW +: AW];

    // type[0] set means HEAD or SINGLE; type[1] set means TAIL or SINGLE
    assign out_valid = (state == FORWARD) & ~empty & PortReserved;
    // IDLE waits out the relieve cycle so switch control is back in UnRouted first
    assign errDrop   = (state == IDLE) & ~empty & ~routeRelieve & ~headType[0];
    assign pop       = (out_valid & out_ready) | errDrop;

    always_comb begin
        routePort = P_LOCAL;
        if (destX > XP)      routePort = P_EAST;
        else if (destX < XP) routePort = P_WEST;
        else if (destY > YP) routePort = P_NORTH;
        else if (destY < YP) routePort = P_SOUTH;
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem[wrPtr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                    <= IDLE;
            routeReserveRequestValid <= 1'b0;
            routeReserveRequest      <= '0;
            routeRelieve             <= 1'b0;
            flit_error               <= 1'b0;
        end else begin
            routeRelieve <= 1'b0;
            flit_error   <= errDrop;
            case (state)
                IDLE: begin
                    if (~empty && ~routeRelieve && headType[0]) begin
                        routeReserveRequest      <= routePort;
                        routeReserveRequestValid <= 1'b1;
                        state                    <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (routeReserveStatus) state <= FORWARD;
                end
                FORWARD: begin
                    if (out_valid && out_ready && headType[1]) begin
                        routeReserveRequestValid <= 1'b0;
                        routeRelieve             <= 1'b1;
                        state                    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_input_port_controller.sv
// Directed bench for input_port_controller at node (1,1) of a 4x4 mesh; output
// flits are checked against a queue of expected flits filled as stimulus is accepted.
module tb_input_port_controller;
    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          routeReserveRequestValid;
    logic [RW-1:0] routeReserveRequest;
    logic          routeRelieve;
    logic          routeReserveStatus;
    logic          PortReserved;
    logic          flit_error;

    int checks = 0;
    int failures = 0;
    int hsCnt = 0;
    int relieveCnt = 0;
    int errCnt = 0;
    logic [DW-1:0] sbq[$];
    logic          prevValid = 1'b0;
    logic [RW-1:0] prevReq = '0;

    input_port_controller #(
        .N(4), .X_POS(1), .Y_POS(1), .DATA_WIDTH(DW), .REQUEST_WIDTH(RW), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .routeReserveRequestValid(routeReserveRequestValid),
        .routeReserveRequest(routeReserveRequest),
        .routeRelieve(routeRelieve),
        .routeReserveStatus(routeReserveStatus),
        .PortReserved(PortReserved),
        .flit_error(flit_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [1:0] dx,
                                         input logic [1:0] dy, input logic [9:0] pl);
        return {t, pl, dy, dx};
    endfunction

    // Handshakes are sampled mid-cycle; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            hsCnt++;
            if (sbq.size() == 0) check("sb_unexpected_flit", sbq.size(), 1);
            else check("sb_data", out_data, sbq.pop_front());
        end
        if (routeRelieve) relieveCnt++;
        if (flit_error) errCnt++;
        if (routeReserveRequestValid && prevValid)
            check("req_stable", routeReserveRequest, prevReq);
        prevValid = routeReserveRequestValid;
        prevReq   = routeReserveRequest;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] f, input bit expectOut, output bit accepted);
        in_data  = f;
        in_valid = 1'b1;
        accepted = in_ready;
        if (accepted && expectOut) sbq.push_back(f);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic grant();
        routeReserveStatus = 1'b1;
        PortReserved = 1'b1;
        tick();
        routeReserveStatus = 1'b0;
    endtask

    task automatic waitRelieve(input int budget);
        int n = 0;
        while (!routeRelieve && n < budget) begin
            tick();
            n++;
        end
        check("relieve_seen", routeRelieve, 1);
        tick();
        PortReserved = 1'b0;
    endtask

    initial begin
        bit acc;
        int accCnt;
        int hs0, rel0, e0;

        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        routeReserveStatus = 1'b0; PortReserved = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", routeReserveRequestValid, 0);
        check("rst_req", routeReserveRequest, 0);
        check("rst_relieve", routeRelieve, 0);
        check("rst_flit_error", flit_error, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // SINGLE to (3,1): EAST
        send(mk(2'b11, 2'd3, 2'd1, 10'h101), 1, acc);
        check("t1_valid_not_yet", routeReserveRequestValid, 0);
        tick();
        check("t1_req_valid", routeReserveRequestValid, 1);
        check("t1_req_port", routeReserveRequest, 1);
        check("t1_out_valid_in_request", out_valid, 0);
        grant();
        check("t1_out_valid", out_valid, 1);
        tick();
        check("t1_relieve", routeRelieve, 1);
        check("t1_valid_dropped", routeReserveRequestValid, 0);
        tick();
        check("t1_relieve_one_cycle", routeRelieve, 0);
        PortReserved = 1'b0;
        tick(); tick();

        // 4-flit packet to (1,0): SOUTH
        rel0 = relieveCnt;
        send(mk(2'b01, 2'd1, 2'd0, 10'h201), 1, acc);
        send(mk(2'b00, 2'd1, 2'd0, 10'h202), 1, acc);
        send(mk(2'b00, 2'd1, 2'd0, 10'h203), 1, acc);
        send(mk(2'b10, 2'd1, 2'd0, 10'h204), 1, acc);
        check("t2_req_valid", routeReserveRequestValid, 1);
        check("t2_req_port", routeReserveRequest, 4);
        hs0 = hsCnt;
        grant();
        tick(); tick(); tick();
        check("t2_no_early_relieve", relieveCnt - rel0, 0);
        tick();
        check("t2_handshakes", hsCnt - hs0, 4);
        check("t2_relieve", routeRelieve, 1);
        tick();
        check("t2_relieve_count", relieveCnt - rel0, 1);
        PortReserved = 1'b0;
        tick(); tick();

        // back-pressure: 6 offered, 4 accepted, order kept across wrap
        out_ready = 1'b0;
        accCnt = 0;
        for (int i = 0; i < 6; i++) begin
            send(mk(i == 0 ? 2'b01 : 2'b00, 2'd3, 2'd1, 10'(10'h300 + i)), 1, acc);
            if (acc) accCnt++;
        end
        check("t3_accepted", accCnt, 4);
        check("t3_req_port", routeReserveRequest, 1);
        for (int i = 0; i < 3; i++) begin
            check("t3_in_ready_full", in_ready, 0);
            tick();
        end
        grant();
        check("t3_in_ready_before_pop", in_ready, 0);
        out_ready = 1'b1;
        tick();
        check("t3_in_ready_after_pop", in_ready, 1);
        send(mk(2'b10, 2'd3, 2'd1, 10'h3ff), 1, acc);
        waitRelieve(20);
        tick(); tick();

        // stray BODY in IDLE is dropped with an error pulse
        e0 = errCnt;
        send(mk(2'b00, 2'd2, 2'd2, 10'h0bd), 0, acc);
        tick();
        check("t4_flit_error", flit_error, 1);
        check("t4_no_request", routeReserveRequestValid, 0);
        tick();
        check("t4_error_one_cycle", flit_error, 0);
        check("t4_error_count", errCnt - e0, 1);
        send(mk(2'b01, 2'd1, 2'd1, 10'h401), 1, acc);
        tick();
        check("t4_req_valid", routeReserveRequestValid, 1);
        check("t4_req_local", routeReserveRequest, 0);
        send(mk(2'b10, 2'd1, 2'd1, 10'h402), 1, acc);
        grant();
        waitRelieve(20);
        tick(); tick();

        // grant withheld 10 cycles, then PortReserved lags the grant
        send(mk(2'b11, 2'd0, 2'd1, 10'h501), 1, acc);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t5_valid_held", routeReserveRequestValid, 1);
            check("t5_port_held", routeReserveRequest, 2);
            check("t5_no_out_valid", out_valid, 0);
            tick();
        end
        routeReserveStatus = 1'b1;
        tick();
        routeReserveStatus = 1'b0;
        check("t5_wait_reserved", out_valid, 0);
        tick();
        check("t5_wait_reserved2", out_valid, 0);
        PortReserved = 1'b1;
        waitRelieve(20);
        tick(); tick();

        // reset mid-packet
        rel0 = relieveCnt;
        send(mk(2'b01, 2'd2, 2'd2, 10'h601), 0, acc);
        send(mk(2'b00, 2'd2, 2'd2, 10'h602), 0, acc);
        check("t6_req_before_rst", routeReserveRequestValid, 1);
        rst = 1'b1;
        tick();
        check("t6_in_ready", in_ready, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_req_valid", routeReserveRequestValid, 0);
        check("t6_req", routeReserveRequest, 0);
        check("t6_relieve", routeRelieve, 0);
        check("t6_flit_error", flit_error, 0);
        rst = 1'b0;
        tick();
        check("t6_fifo_empty_ready", in_ready, 1);
        tick();
        check("t6_no_stale_request", routeReserveRequestValid, 0);
        check("t6_no_relieve", relieveCnt - rel0, 0);
        send(mk(2'b11, 2'd1, 2'd2, 10'h603), 1, acc);
        tick();
        check("t6_new_req_north", routeReserveRequest, 3);
        grant();
        waitRelieve(20);
        tick(); tick();

        check("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
